// File: rtl/panel_reg_pkg.sv
// Shared constants and types for the panel register bank: register map
// addresses, CTRL bit positions, LOCK keys and the commit FSM state type.
package panel_reg_pkg;

  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_STATUS     = 8'h01;
  localparam logic [7:0] ADDR_IRQ_STATUS = 8'h02;
  localparam logic [7:0] ADDR_IRQ_MASK   = 8'h03;
  localparam logic [7:0] ADDR_VERSION    = 8'h04;
  localparam logic [7:0] ADDR_LOCK       = 8'h05;

  localparam int CTRL_IDLE_BIT   = 0;
  localparam int CTRL_FSTART_BIT = 1;
  localparam int CTRL_FRESET_BIT = 2;
  localparam int CTRL_COMMIT_BIT = 3;

  localparam logic [7:0] LOCK_KEY_SET = 8'hA5;
  localparam logic [7:0] LOCK_KEY_CLR = 8'h5A;

  typedef enum logic {
    CM_IDLE = 1'b0,
    CM_PEND = 1'b1
  } commit_state_t;

endpackage

// File: rtl/panel_reg_bank_if.sv
// Host request/response channel of the panel register bank.
// The host drives requests and accepts responses (master); the bank
// accepts requests and returns one registered response each (slave).
interface panel_reg_bank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/panel_irq_ctrl.sv
// Sticky interrupt status with mask and write-1-to-clear. A source that is
// set in the same cycle as a clear wins; changing the mask never clears
// bits already latched. The irq level is registered from the status.
module panel_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic               mask_we_i,
  input  logic [NUM_IRQ-1:0] mask_wdata_i,
  input  logic [NUM_IRQ-1:0] w1c_i,
  output logic [NUM_IRQ-1:0] status_o,
  output logic [NUM_IRQ-1:0] mask_o,
  output logic               irq_o
);

  logic [NUM_IRQ-1:0] status_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic               irq_q;

  // Latch masked sources, clear on W1C, register the OR for the irq line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= (status_q & ~w1c_i) | (irq_src_i & mask_q);
      mask_q   <= mask_we_i ? mask_wdata_i : mask_q;
      irq_q    <= |status_q;
    end
  end

  assign status_o = status_q;
  assign mask_o   = mask_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/panel_reg_bank.sv
// Control/status register bank for the TFT panel FPGA.
// One outstanding host transaction, response latency of one cycle.
// Config registers are double-buffered: host writes land in shadows and are
// copied to the active set at a frame boundary (or at once while idle).
// Optional feature macro: REG_LOCK_EN (adds the LOCK register at 0x05).
module panel_reg_bank
  import panel_reg_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 8,
  parameter int                NUM_CFG    = 16,
  parameter int                NUM_IRQ    = 8,
  parameter int                NUM_STAT   = 8,
  parameter logic [ADDR_W-1:0] CFG_BASE   = ADDR_W'(8'h10),
  parameter logic [31:0]       FW_VERSION = 32'h56313030
) (
  input  logic                      clk,
  input  logic                      rst_n,
  panel_reg_bank_if.slave           bus,
  input  logic                      frame_boundary,
  input  logic [NUM_STAT-1:0]       status_in,
  input  logic [NUM_IRQ-1:0]        irq_src,
  output logic [NUM_CFG*DATA_W-1:0] cfg_active,
  output logic                      idle_mode,
  output logic                      frame_start,
  output logic                      frame_reset,
  output logic                      commit_pending,
  output logic                      irq
);

  localparam int IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam logic [ADDR_W-1:0] A_CTRL       = ADDR_W'(ADDR_CTRL);
  localparam logic [ADDR_W-1:0] A_STATUS     = ADDR_W'(ADDR_STATUS);
  localparam logic [ADDR_W-1:0] A_IRQ_STATUS = ADDR_W'(ADDR_IRQ_STATUS);
  localparam logic [ADDR_W-1:0] A_IRQ_MASK   = ADDR_W'(ADDR_IRQ_MASK);
  localparam logic [ADDR_W-1:0] A_VERSION    = ADDR_W'(ADDR_VERSION);

  logic                            resp_valid_q, resp_err_q, err_d;
  logic [DATA_W-1:0]               resp_rdata_q, rdata_d;
  logic                            idle_q, fstart_q, freset_q;
  commit_state_t                   state_q, state_d;
  logic [NUM_CFG-1:0][DATA_W-1:0]  shadow_q, shadow_d, active_q;
  logic                            accept_s, lock_s, commit_now_s, commit_req_s;
  logic                            cfg_we_s, mask_we_s, ctrl_we_s, lock_we_s;
  logic [NUM_IRQ-1:0]              w1c_s, irq_status_s, irq_mask_s;
  logic [ADDR_W:0]                 cfg_off_s;
  logic                            in_cfg_s;
  logic [IDX_W-1:0]                cfg_idx_s;

  assign bus.req_ready = !resp_valid_q || bus.resp_ready;
  assign accept_s      = bus.req_valid && bus.req_ready;

  // An address below CFG_BASE wraps to a huge offset and falls out of range.
  assign cfg_off_s = {1'b0, bus.req_addr} - {1'b0, CFG_BASE};
  assign in_cfg_s  = cfg_off_s < (ADDR_W+1)'(NUM_CFG);
  assign cfg_idx_s = cfg_off_s[IDX_W-1:0];

`ifdef REG_LOCK_EN
  logic lock_q;
  assign lock_s = lock_q;
`else
  assign lock_s = 1'b0;
`endif

  // Address decode: read data, error flag and write enables for this request.
  always_comb begin
    rdata_d   = '0;
    err_d     = 1'b0;
    cfg_we_s  = 1'b0;
    mask_we_s = 1'b0;
    ctrl_we_s = 1'b0;
    lock_we_s = 1'b0;
    w1c_s     = '0;
    if (in_cfg_s) begin
      if (!bus.req_write) begin
        rdata_d = shadow_q[cfg_idx_s];
      end else if (lock_s) begin
        err_d = 1'b1;
      end else begin
        cfg_we_s = accept_s;
      end
    end else begin
      case (bus.req_addr)
        A_CTRL: begin
          if (bus.req_write) ctrl_we_s = accept_s;
          else               rdata_d   = DATA_W'(idle_q);
        end
        A_STATUS: begin
          if (bus.req_write) err_d   = 1'b1;
          else               rdata_d = DATA_W'(status_in);
        end
        A_IRQ_STATUS: begin
          if (bus.req_write) w1c_s   = accept_s ? bus.req_wdata[NUM_IRQ-1:0] : '0;
          else               rdata_d = DATA_W'(irq_status_s);
        end
        A_IRQ_MASK: begin
          if (!bus.req_write) rdata_d   = DATA_W'(irq_mask_s);
          else if (lock_s)    err_d     = 1'b1;
          else                mask_we_s = accept_s;
        end
        A_VERSION: begin
          if (bus.req_write) err_d   = 1'b1;
          else               rdata_d = FW_VERSION[DATA_W-1:0];
        end
`ifdef REG_LOCK_EN
        ADDR_W'(ADDR_LOCK): begin
          if (bus.req_write) lock_we_s = accept_s;
          else               rdata_d   = DATA_W'(lock_q);
        end
`endif
        default: err_d = 1'b1;
      endcase
    end
  end

  assign commit_req_s = ctrl_we_s && bus.req_wdata[CTRL_COMMIT_BIT];
  assign commit_now_s = (state_q == CM_PEND) && (frame_boundary || idle_q);

  // Shadow next state; a write in the commit cycle is forwarded to active.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we_s) shadow_d[cfg_idx_s] = bus.req_wdata;
    else          shadow_d = shadow_q;
  end

  // Commit FSM next state: armed by cfg writes or CTRL commit request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CM_IDLE: begin
        if (cfg_we_s || commit_req_s) state_d = CM_PEND;
        else                          state_d = CM_IDLE;
      end
      CM_PEND: begin
        if (commit_now_s) state_d = CM_IDLE;
        else              state_d = CM_PEND;
      end
      default: state_d = CM_IDLE;
    endcase
  end

  // Response register: load on accept, hold until the host consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else if (accept_s) begin
      resp_valid_q <= 1'b1;
      resp_rdata_q <= rdata_d;
      resp_err_q   <= err_d;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end
  end

  // CTRL state, one-cycle frame pulses, commit FSM and config registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q   <= 1'b0;
      fstart_q <= 1'b0;
      freset_q <= 1'b0;
      state_q  <= CM_IDLE;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      idle_q   <= ctrl_we_s ? bus.req_wdata[CTRL_IDLE_BIT] : idle_q;
      fstart_q <= ctrl_we_s && bus.req_wdata[CTRL_FSTART_BIT];
      freset_q <= ctrl_we_s && bus.req_wdata[CTRL_FRESET_BIT];
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= commit_now_s ? shadow_d : active_q;
    end
  end

`ifdef REG_LOCK_EN
  // Lock register: only the two keys change it, other values are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (lock_we_s && bus.req_wdata == DATA_W'(LOCK_KEY_SET)) begin
      lock_q <= 1'b1;
    end else if (lock_we_s && bus.req_wdata == DATA_W'(LOCK_KEY_CLR)) begin
      lock_q <= 1'b0;
    end
  end
`endif

  panel_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_src_i    (irq_src),
    .mask_we_i    (mask_we_s),
    .mask_wdata_i (bus.req_wdata[NUM_IRQ-1:0]),
    .w1c_i        (w1c_s),
    .status_o     (irq_status_s),
    .mask_o       (irq_mask_s),
    .irq_o        (irq)
  );

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign cfg_active     = active_q;
  assign idle_mode      = idle_q;
  assign frame_start    = fstart_q;
  assign frame_reset    = freset_q;
  assign commit_pending = (state_q == CM_PEND);

endmodule

// File: tb/tb_panel_reg_bank.sv
// Scoreboard bench for panel_reg_bank: directed test-plan steps followed by
// random traffic, checked against a register-map level reference model.
module tb_panel_reg_bank;

  localparam int          DATA_W     = 32;
  localparam int          ADDR_W     = 8;
  localparam int          NUM_CFG    = 16;
  localparam int          NUM_IRQ    = 8;
  localparam int          NUM_STAT   = 8;
  localparam logic [7:0]  CFG_BASE   = 8'h10;
  localparam logic [31:0] FW_VERSION = 32'h56313030;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  panel_reg_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic                      frame_boundary;
  logic [NUM_STAT-1:0]       status_in;
  logic [NUM_IRQ-1:0]        irq_src;
  logic [NUM_CFG*DATA_W-1:0] cfg_active;
  logic idle_mode, frame_start, frame_reset, commit_pending, irq;

  panel_reg_bank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CFG(NUM_CFG), .NUM_IRQ(NUM_IRQ),
    .NUM_STAT(NUM_STAT), .CFG_BASE(CFG_BASE), .FW_VERSION(FW_VERSION)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .frame_boundary(frame_boundary),
    .status_in(status_in), .irq_src(irq_src), .cfg_active(cfg_active),
    .idle_mode(idle_mode), .frame_start(frame_start), .frame_reset(frame_reset),
    .commit_pending(commit_pending), .irq(irq)
  );

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;
  exp_t exp_q[$];

  // Reference model of the register map.
  logic [DATA_W-1:0]  m_shadow [NUM_CFG];
  logic [DATA_W-1:0]  m_active [NUM_CFG];
  logic [NUM_IRQ-1:0] m_st, m_mask;
  logic m_idle, m_fs, m_fr, m_pend, m_irq, m_rv, m_lock;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CFG; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_st = '0; m_mask = '0;
    m_idle = 1'b0; m_fs = 1'b0; m_fr = 1'b0; m_pend = 1'b0;
    m_irq = 1'b0; m_rv = 1'b0; m_lock = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_state();
    logic [NUM_CFG*DATA_W-1:0] e;
    for (int k = 0; k < NUM_CFG; k++) e[k*DATA_W +: DATA_W] = m_active[k];
    total++;
    if (cfg_active !== e) begin
      bad++;
      $display("FAIL cfg_active got=%h want=%h", cfg_active, e);
    end
    chk("commit_pending", 64'(commit_pending), 64'(m_pend));
    chk("irq", 64'(irq), 64'(m_irq));
    chk("idle_mode", 64'(idle_mode), 64'(m_idle));
    chk("frame_start", 64'(frame_start), 64'(m_fs));
    chk("frame_reset", 64'(frame_reset), 64'(m_fr));
    chk("resp_valid", 64'(bus.resp_valid), 64'(m_rv));
  endtask

  // One clock cycle: check state, drive inputs, step the model, advance.
  task automatic cycle(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic rr, input logic fb,
                       input logic [NUM_IRQ-1:0] src, input logic [NUM_STAT-1:0] st);
    logic acc, er, cfgw, creq, commit;
    logic [DATA_W-1:0]  rd;
    logic [NUM_IRQ-1:0] w1c, new_mask;
    logic new_idle, new_lock, fs, fr;
    logic [DATA_W-1:0]  sh [NUM_CFG];
    int off;
    check_state();
    bus.req_valid = v; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    bus.resp_ready = rr; frame_boundary = fb; irq_src = src; status_in = st;
    #1;
    chk("req_ready", 64'(bus.req_ready), 64'(!m_rv || rr));
    acc = v && (!m_rv || rr);
    rd = '0; er = 1'b0; cfgw = 1'b0; creq = 1'b0; w1c = '0;
    new_mask = m_mask; new_idle = m_idle; new_lock = m_lock; fs = 1'b0; fr = 1'b0;
    sh = m_shadow;
    if (acc) begin
      off = int'(a) - int'(CFG_BASE);
      if (off >= 0 && off < NUM_CFG) begin
        if (!w) rd = m_shadow[off];
        else if (m_lock) er = 1'b1;
        else begin sh[off] = d; cfgw = 1'b1; end
      end else if (a == 8'h00) begin
        if (w) begin new_idle = d[0]; fs = d[1]; fr = d[2]; creq = d[3]; end
        else rd = DATA_W'(m_idle);
      end else if (a == 8'h01) begin
        if (w) er = 1'b1; else rd = DATA_W'(st);
      end else if (a == 8'h02) begin
        if (w) w1c = d[NUM_IRQ-1:0]; else rd = DATA_W'(m_st);
      end else if (a == 8'h03) begin
        if (!w) rd = DATA_W'(m_mask);
        else if (m_lock) er = 1'b1;
        else new_mask = d[NUM_IRQ-1:0];
      end else if (a == 8'h04) begin
        if (w) er = 1'b1; else rd = FW_VERSION;
`ifdef REG_LOCK_EN
      end else if (a == 8'h05) begin
        if (!w) rd = DATA_W'(m_lock);
        else if (d == 32'h000000A5) new_lock = 1'b1;
        else if (d == 32'h0000005A) new_lock = 1'b0;
`endif
      end else begin
        er = 1'b1;
      end
      exp_q.push_back('{rdata: rd, err: er});
    end
    m_irq  = |m_st;
    m_st   = (m_st & ~w1c) | (src & m_mask);
    m_mask = new_mask;
    commit = m_pend && (fb || m_idle);
    if (commit) m_active = sh;
    m_pend   = commit ? 1'b0 : (m_pend || cfgw || creq);
    m_shadow = sh;
    m_idle = new_idle; m_fs = fs; m_fr = fr; m_lock = new_lock;
    m_rv = acc ? 1'b1 : (rr ? 1'b0 : m_rv);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
  endtask

  // Monitor: compare every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected got rdata=%0h err=%0b want none",
                 bus.resp_rdata, bus.resp_err);
      end else begin
        chk("resp_rdata", 64'(bus.resp_rdata), 64'(exp_q[0].rdata));
        chk("resp_err", 64'(bus.resp_err), 64'(exp_q[0].err));
        if (bus.resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int sel;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.resp_ready = 1'b0;
    frame_boundary = 1'b0; status_in = '0; irq_src = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("reset_err", 64'(bus.resp_err), 64'd0);
    rst_n = 1'b1;

    // Version and status reads.
    cycle(1'b1, 1'b0, 8'h04, '0, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 8'h01, '0, 1'b1, 1'b0, '0, 8'h2C);
    idle(1);
    // Shadow write, read back, commit on frame boundary.
    cycle(1'b1, 1'b1, 8'h13, 32'h1234, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 8'h13, '0, 1'b1, 1'b0, '0, '0);
    idle(2);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, '0, '0);
    idle(2);
    // Backpressure: response held three cycles, then back-to-back accept.
    cycle(1'b1, 1'b0, 8'h04, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h13, '0, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 8'h13, '0, 1'b1, 1'b0, '0, '0);
    idle(1);
    // Interrupts: mask, latch, W1C racing a set, final clear.
    cycle(1'b1, 1'b1, 8'h03, 32'h05, 1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h07, '0);
    idle(2);
    cycle(1'b1, 1'b1, 8'h02, 32'h01, 1'b1, 1'b0, 8'h01, '0);
    cycle(1'b1, 1'b0, 8'h02, '0, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 8'h02, 32'h05, 1'b1, 1'b0, '0, '0);
    idle(3);
    // Errors and CTRL pulses.
    cycle(1'b1, 1'b0, 8'h3F, '0, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 8'h01, 32'hFF, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 8'h00, 32'h6, 1'b1, 1'b0, '0, '0);
    idle(2);
`ifdef REG_LOCK_EN
    cycle(1'b1, 1'b1, 8'h05, 32'hA5, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 8'h10, 32'hBEEF, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 8'h05, '0, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 8'h05, 32'h5A, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 8'h10, 32'hBEEF, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, '0, '0);
    idle(2);
`endif
    // Reset with a response outstanding and a commit pending.
    cycle(1'b1, 1'b1, 8'h15, 32'hCAFE, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 8'h04, '0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Random traffic.
    for (int it = 0; it < 3000; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      a = ADDR_W'(sel);
      else if (sel <= 7) a = CFG_BASE + ADDR_W'($urandom_range(0, NUM_CFG - 1));
      else if (sel == 8) a = ADDR_W'($urandom);
      else               a = ($urandom_range(0, 1) == 0) ? CFG_BASE - 8'd1 : CFG_BASE + 8'd16;
      d = $urandom;
      if (a == 8'h00 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      if (a == 8'h05) begin
        sel = int'($urandom_range(0, 2));
        d = (sel == 0) ? 32'hA5 : ((sel == 1) ? 32'h5A : d);
      end
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0) ? NUM_IRQ'($urandom) : '0,
            NUM_STAT'($urandom));
    end
    idle(4);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
